// File: rtl/merger_kway_node.sv
// merger_kway_node: K-way merge node.
// Each cycle it picks the smallest non-terminator key among K show-ahead
// input FIFO heads and pushes that element into a small output buffer.
// A terminator (key == 0) marks the end of a run. When every head is a
// terminator, all K streams are popped together and one terminator is
// forwarded, so each output run is closed exactly once.
// Optional feature macro: MERGER_KWAY_ORDER_CHECK_EN adds o_order_err, a
// sticky flag for a stream that delivered a key smaller than its previous key.

module merger_kway_node #(
    parameter int K          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [K*DATA_WIDTH-1:0] i_fifo,
    input  logic [K-1:0]            i_fifo_empty,
    output logic [K-1:0]            o_fifo_read,
    input  logic                    i_fifo_out_ready,
    output logic                    o_out_fifo_write,
    output logic [DATA_WIDTH-1:0]   o_data
`ifdef MERGER_KWAY_ORDER_CHECK_EN
    ,
    output logic                    o_order_err
`endif
);

    localparam int IDX_W = $clog2(K);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Input heads viewed as one element per stream.
    logic [K-1:0][DATA_WIDTH-1:0] head;
    assign head = i_fifo;

    // Tournament tree in heap order: node n has children 2n and 2n+1, leaf
    // K+j is stream j, node 1 is the winner. Lower stream indices always sit
    // in the left subtree, so keeping the left side on a tie gives
    // lowest-index-wins.
    logic [2*K-1:1]                t_vld;
    logic [2*K-1:1][KEY_WIDTH-1:0] t_key;
    logic [2*K-1:1][IDX_W-1:0]     t_idx;

    logic                  any_elig;
    logic [IDX_W-1:0]      sel_idx;
    logic [KEY_WIDTH-1:0]  sel_key;

    logic                  all_valid;
    logic                  space;
    logic                  fire;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    logic [OUT_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_wr;

    // Combinational min-selection tree; terminators and empty heads are ineligible.
    always_comb begin
        t_vld = '0;
        t_key = '0;
        t_idx = '0;
        for (int j = 0; j < K; j++) begin
            t_vld[K+j] = ~i_fifo_empty[j] & (head[j][KEY_WIDTH-1:0] != '0);
            t_key[K+j] = head[j][KEY_WIDTH-1:0];
            t_idx[K+j] = IDX_W'(j);
        end
        for (int n = K - 1; n >= 1; n--) begin
            if (t_vld[2*n+1] & (~t_vld[2*n] | (t_key[2*n+1] < t_key[2*n]))) begin
                t_vld[n] = 1'b1;
                t_key[n] = t_key[2*n+1];
                t_idx[n] = t_idx[2*n+1];
            end else begin
                t_vld[n] = t_vld[2*n];
                t_key[n] = t_key[2*n];
                t_idx[n] = t_idx[2*n];
            end
        end
    end

    assign any_elig = t_vld[1];
    assign sel_idx  = t_idx[1];
    assign sel_key  = t_key[1];

    // Output side: drain the buffer head whenever downstream is ready.
    assign out_wr = i_rst_n & (cnt_q != '0) & i_fifo_out_ready;
    assign pop    = out_wr;

    // A slot is free if the buffer is not full or the head leaves this cycle.
    // Every stream must present a head so the minimum is known to be global.
    assign all_valid = ~|i_fifo_empty;
    assign space     = (cnt_q < CNT_W'(OUT_DEPTH)) | out_wr;
    assign fire      = i_rst_n & all_valid & space;
    assign push      = fire;
    assign push_data = any_elig ? head[sel_idx] : head[0];

    // Pop strobes: the winner alone, or every stream when all heads end a run.
    always_comb begin
        o_fifo_read = '0;
        if (fire) begin
            if (any_elig) begin
                o_fifo_read = K'(1) << sel_idx;
            end else begin
                o_fifo_read = '1;
            end
        end
    end

    // Buffer bookkeeping: pointers wrap naturally since OUT_DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer storage; contents are don't-care while count says empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign o_out_fifo_write = out_wr;
    assign o_data           = mem_q[rd_ptr_q];

`ifdef MERGER_KWAY_ORDER_CHECK_EN
    logic [K-1:0][KEY_WIDTH-1:0] last_key_q, last_key_d;
    logic                        err_q, err_d;

    // Track the last key popped per stream; a run end forgets history.
    always_comb begin
        last_key_d = last_key_q;
        err_d      = err_q;
        if (fire & any_elig) begin
            if ((last_key_q[sel_idx] != '0) && (sel_key < last_key_q[sel_idx])) begin
                err_d = 1'b1;
            end
            last_key_d[sel_idx] = sel_key;
        end else if (fire) begin
            last_key_d = '0;
        end
    end

    // Order-check state; the error flag is sticky until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_key_q <= '0;
            err_q      <= 1'b0;
        end else begin
            last_key_q <= last_key_d;
            err_q      <= err_d;
        end
    end

    assign o_order_err = err_q;
`endif

endmodule

// File: tb/tb_merger_kway_node.sv
// Directed bench for merger_kway_node: show-ahead input FIFO model per stream,
// expected output queue filled as stimulus is loaded, popped on each write.
module tb_merger_kway_node;
    localparam int K  = 4;
    localparam int DW = 32;
    localparam int OD = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [K*DW-1:0] fifo;
    logic [K-1:0]    empty;
    logic [K-1:0]    rd;
    logic            ready;
    logic            wr;
    logic [DW-1:0]   data;
`ifdef MERGER_KWAY_ORDER_CHECK_EN
    logic            oerr;
`endif

    always #5 clk = ~clk;

    merger_kway_node #(.K(K), .DATA_WIDTH(DW), .KEY_WIDTH(DW), .OUT_DEPTH(OD)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_fifo          (fifo),
        .i_fifo_empty    (empty),
        .o_fifo_read     (rd),
        .i_fifo_out_ready(ready),
        .o_out_fifo_write(wr),
        .o_data          (data)
`ifdef MERGER_KWAY_ORDER_CHECK_EN
        ,
        .o_order_err     (oerr)
`endif
    );

    logic [DW-1:0] sq[K][$];
    logic [DW-1:0] exp_q[$];
    logic [K-1:0]  hold;
    logic [K-1:0]  rd_s;
    logic          wr_s;
    int            vec;
    int            miss;
    int            term_rd;
    int            bad_rd;
    int            nwr;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int j = 0; j < K; j++) begin
            empty[j] = (sq[j].size() == 0) | hold[j];
            fifo[j*DW +: DW] = (sq[j].size() != 0) ? sq[j][0] : '0;
        end
    endtask

    task automatic ld(input int j, input logic [DW-1:0] v);
        sq[j].push_back(v);
    endtask

    // One clock: sample outputs mid-cycle, check any write, then apply pops.
    task automatic step();
        logic [DW-1:0] e;
        @(negedge clk);
        rd_s = rd;
        wr_s = wr;
        if (rd_s == '1) term_rd++;
        else if ((rd_s != '0) && !$onehot(rd_s)) bad_rd++;
        if (wr_s) begin
            nwr++;
            vec++;
            assert (exp_q.size() != 0) else begin
                miss++;
                $error("FAIL out_extra observed=%0h expected=none", data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", data, e);
            end
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < K; j++) begin
            if (rd_s[j]) begin
                vec++;
                assert (sq[j].size() != 0) else begin
                    miss++;
                    $error("FAIL pop_empty stream=%0d observed=read expected=no_read", j);
                end
                if (sq[j].size() != 0) void'(sq[j].pop_front());
            end
        end
        drive();
    endtask

    task automatic drain(input string tag, input int bound);
        int s;
        s = 0;
        while ((exp_q.size() != 0) && (s < bound)) begin
            step();
            s++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int s;
        int npop;
        int nwr0;
        vec = 0; miss = 0; term_rd = 0; bad_rd = 0; nwr = 0;
        rst_n = 1'b0; ready = 1'b1; hold = '0; fifo = '0; empty = '1;

        // Reset with data present: no pops, no writes.
        ld(0, 1); ld(0, 5); ld(0, 9); ld(0, 0);
        ld(1, 2); ld(1, 6); ld(1, 0);
        ld(2, 3); ld(2, 0);
        ld(3, 4); ld(3, 7); ld(3, 8); ld(3, 0);
        for (int v = 1; v <= 9; v++) exp_q.push_back(DW'(v));
        exp_q.push_back(0);
        drive();
        repeat (3) begin
            step();
            chk("rst_rd", rd_s, 0);
            chk("rst_wr", wr_s, 0);
        end

        // Release; first write two cycles later, then one element per cycle.
        rst_n = 1'b1;
        first = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (wr_s) begin
                first = c;
                break;
            end
        end
        chk("first_wr_lat", first, 2);
        s = 0;
        while ((exp_q.size() != 0) && (s < 50)) begin
            step();
            s++;
        end
        chk("merge_thru", s, 9);
        chk("merge_drained", exp_q.size(), 0);
        chk("merge_nwr", nwr, 10);
        chk("merge_term_rd", term_rd, 1);
        chk("merge_bad_rd", bad_rd, 0);

        // Tie: equal keys pop in stream index order, then one terminator.
        for (int j = 0; j < K; j++) begin
            ld(j, 7); ld(j, 0);
            exp_q.push_back(7);
        end
        exp_q.push_back(0);
        drive();
        step(); chk("tie_rd0", rd_s, 4'b0001);
        step(); chk("tie_rd1", rd_s, 4'b0010);
        step(); chk("tie_rd2", rd_s, 4'b0100);
        step(); chk("tie_rd3", rd_s, 4'b1000);
        step(); chk("tie_rdT", rd_s, 4'b1111);
        drain("tie_drained", 20);

        // Backpressure: buffer fills after two pops, then resumes cleanly.
        ready = 1'b0;
        ld(0, 10); ld(0, 20); ld(0, 0);
        ld(1, 11); ld(1, 21); ld(1, 0);
        ld(2, 12); ld(2, 0);
        ld(3, 13); ld(3, 0);
        exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(12); exp_q.push_back(13);
        exp_q.push_back(20); exp_q.push_back(21); exp_q.push_back(0);
        drive();
        npop = 0;
        nwr0 = nwr;
        repeat (5) begin
            step();
            if (rd_s != '0) npop++;
        end
        chk("bp_pops", npop, 2);
        chk("bp_rd_idle", rd_s, 0);
        chk("bp_no_wr", nwr - nwr0, 0);
        ready = 1'b1;
        drain("bp_drained", 30);

        // Empty stall: one empty stream blocks all selection.
        hold = 4'b0100;
        ld(0, 30); ld(0, 40); ld(0, 0);
        ld(1, 31); ld(1, 0);
        ld(2, 32); ld(2, 0);
        ld(3, 33); ld(3, 0);
        exp_q.push_back(30); exp_q.push_back(31); exp_q.push_back(32);
        exp_q.push_back(33); exp_q.push_back(40); exp_q.push_back(0);
        drive();
        npop = 0;
        nwr0 = nwr;
        repeat (3) begin
            step();
            if (rd_s != '0) npop++;
        end
        chk("stall_pops", npop, 0);
        chk("stall_no_wr", nwr - nwr0, 0);
        hold = '0;
        drive();
        drain("stall_drained", 30);

`ifdef MERGER_KWAY_ORDER_CHECK_EN
        // Descending keys within one run raise the sticky error flag.
        chk("oerr_init", oerr, 0);
        ld(0, 0); ld(1, 4); ld(1, 3); ld(1, 0); ld(2, 0); ld(3, 0);
        exp_q.push_back(4); exp_q.push_back(3); exp_q.push_back(0);
        drive();
        step(); chk("oerr_first", oerr, 0);
        step(); chk("oerr_set", oerr, 1);
        drain("oerr_drained", 20);
        chk("oerr_sticky", oerr, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("oerr_rst", oerr, 0);
        // A terminator between keys starts a new run: no error.
        ld(0, 0); ld(0, 0);
        ld(1, 4); ld(1, 0); ld(1, 3); ld(1, 0);
        ld(2, 0); ld(2, 0);
        ld(3, 0); ld(3, 0);
        exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
        drive();
        drain("oerr2_drained", 20);
        chk("oerr_run_reset", oerr, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
